// File: rtl/irs_dma_sequencer.sv
// rtl/irs_dma_sequencer.sv - DMA sequencer streaming enabled IRS daughter buffers into the event FIFO
module irs_dma_sequencer #(
  parameter int NUM_DAUGHTERS = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int COUNT_WIDTH   = 12,
  parameter int COUNT_SHIFT   = 6,
  parameter int NMXD_BITS     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [3:0]            addr_i,
  input  logic [7:0]            dat_i,
  input  logic                  wr_i,
  output logic [7:0]            dat_o,
  input  logic [DATA_WIDTH-1:0] irs_dat_i,
  input  logic                  irs_valid_i,
  output logic                  irs_read_o,
  output logic [NMXD_BITS-1:0]  irs_addr_o,
  input  logic                  event_full_i,
  output logic [DATA_WIDTH-1:0] event_dat_o,
  output logic                  event_wr_o,
  output logic                  event_first_o,
  output logic                  event_last_o,
  output logic                  active_o,
  output logic                  done_o
);
  localparam int BW = COUNT_WIDTH - COUNT_SHIFT;
  localparam int SW = NMXD_BITS + 1;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_XFER, S_SWITCH, S_DONE} state_t;

  state_t                 r_state;
  logic [BW-1:0]          r_blocks [NUM_DAUGHTERS];
  logic [NUM_DAUGHTERS-1:0] r_mask;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [SW-1:0]          r_scan;
  logic [NMXD_BITS-1:0]   r_irs_addr;
  logic                   r_active;
  logic                   r_done;
  logic                   r_done_flag;
  logic                   r_aborted;
  logic                   r_first_pending;
  logic                   r_event_wr;
  logic [DATA_WIDTH-1:0]  r_event_dat;
  logic                   r_event_first;
  logic                   r_event_last;

  logic                   w_csr_wr;
  logic                   w_start;
  logic                   w_abort;
  logic                   w_clear;
  logic                   w_idle;
  logic                   w_final;
  logic                   w_found;
  logic [NMXD_BITS-1:0]   w_pick;
  logic [BW-1:0]          w_pick_blocks;
  logic                   w_higher;
  logic [7:0]             w_rd_data;
  logic                   w_unused_dat;

  assign w_csr_wr     = wr_i && (addr_i == 4'd8);
  assign w_start      = w_csr_wr && dat_i[0];
  assign w_abort      = w_csr_wr && dat_i[1];
  assign w_clear      = w_csr_wr && dat_i[2];
  assign w_idle       = (r_state == S_IDLE);
  assign w_unused_dat = ^dat_i;

  // The final word's own valid cycle already drops the read, so no daughter is over-read.
  assign w_final    = (r_state == S_XFER) && irs_valid_i && (r_cnt == '0);
  assign irs_read_o = (r_state == S_XFER) && !event_full_i && !w_final && !w_abort;

  always_comb begin
    w_found       = 1'b0;
    w_pick        = '0;
    w_pick_blocks = '0;
    w_higher      = 1'b0;
    for (int i = NUM_DAUGHTERS - 1; i >= 0; i--) begin
      if (r_mask[i] && (SW'(i) >= r_scan)) begin
        w_found       = 1'b1;
        w_pick        = NMXD_BITS'(i);
        w_pick_blocks = r_blocks[i];
      end
      if (r_mask[i] && (NMXD_BITS'(i) > r_irs_addr)) begin
        w_higher = 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    for (int i = 0; i < NUM_DAUGHTERS; i++) begin
      if (addr_i == 4'(i)) begin
        w_rd_data = 8'(r_blocks[i]);
      end
    end
    if (addr_i == 4'd8) begin
      w_rd_data = {5'b00000, r_aborted, r_done_flag, r_active};
    end
    if (addr_i == 4'd9) begin
      w_rd_data = 8'(r_mask);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state         <= S_IDLE;
      for (int i = 0; i < NUM_DAUGHTERS; i++) begin
        r_blocks[i] <= '0;
      end
      r_mask          <= '1;
      r_cnt           <= '0;
      r_scan          <= '0;
      r_irs_addr      <= '0;
      r_active        <= 1'b0;
      r_done          <= 1'b0;
      r_done_flag     <= 1'b0;
      r_aborted       <= 1'b0;
      r_first_pending <= 1'b0;
      r_event_wr      <= 1'b0;
      r_event_dat     <= '0;
      r_event_first   <= 1'b0;
      r_event_last    <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_event_wr    <= 1'b0;
      r_event_first <= 1'b0;
      r_event_last  <= 1'b0;

      if (wr_i && w_idle) begin
        for (int i = 0; i < NUM_DAUGHTERS; i++) begin
          if (addr_i == 4'(i)) begin
            r_blocks[i] <= dat_i[BW-1:0];
          end
        end
        if (addr_i == 4'd9) begin
          r_mask <= dat_i[NUM_DAUGHTERS-1:0];
        end
        if (w_clear) begin
          r_done_flag <= 1'b0;
          r_aborted   <= 1'b0;
        end
      end

      // A word already in flight when abort lands is still delivered, but never tagged last.
      if ((r_state == S_XFER) && irs_valid_i) begin
        r_event_wr      <= 1'b1;
        r_event_dat     <= irs_dat_i;
        r_event_first   <= r_first_pending;
        r_first_pending <= 1'b0;
        r_event_last    <= w_final && !w_higher && !w_abort;
      end

      if (w_abort && !w_idle && (r_state != S_DONE)) begin
        r_state   <= S_IDLE;
        r_active  <= 1'b0;
        r_done    <= 1'b1;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start && !w_abort) begin
              r_state         <= S_SELECT;
              r_active        <= 1'b1;
              r_scan          <= '0;
              r_first_pending <= 1'b1;
            end
          end
          S_SELECT: begin
            if (w_found) begin
              r_irs_addr <= w_pick;
              r_cnt      <= {w_pick_blocks, {COUNT_SHIFT{1'b0}}};
              r_state    <= S_XFER;
            end else begin
              r_state     <= S_DONE;
              r_active    <= 1'b0;
              r_done      <= 1'b1;
              r_done_flag <= 1'b1;
            end
          end
          S_XFER: begin
            if (irs_valid_i) begin
              if (r_cnt == '0) begin
                r_state <= S_SWITCH;
              end else begin
                r_cnt <= r_cnt - 1'b1;
              end
            end
          end
          S_SWITCH: begin
            r_scan  <= SW'(r_irs_addr) + SW'(1);
            r_state <= S_SELECT;
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign dat_o         = w_rd_data;
  assign irs_addr_o    = r_irs_addr;
  assign event_dat_o   = r_event_dat;
  assign event_wr_o    = r_event_wr;
  assign event_first_o = r_event_first;
  assign event_last_o  = r_event_last;
  assign active_o      = r_active;
  assign done_o        = r_done;

endmodule

// File: tb/tb_irs_dma_sequencer.sv
// tb/tb_irs_dma_sequencer.sv - randomized self-checking bench for irs_dma_sequencer
module tb_irs_dma_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr;
  logic [7:0]  wdat;
  logic        wr;
  logic [7:0]  rdat;
  logic [15:0] irs_dat;
  logic        irs_valid;
  logic        irs_read;
  logic [2:0]  irs_addr;
  logic        event_full;
  logic [15:0] ev_dat;
  logic        ev_wr, ev_first, ev_last, active, done;

  irs_dma_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .dat_i(wdat), .wr_i(wr), .dat_o(rdat),
    .irs_dat_i(irs_dat), .irs_valid_i(irs_valid), .irs_read_o(irs_read), .irs_addr_o(irs_addr),
    .event_full_i(event_full), .event_dat_o(ev_dat), .event_wr_o(ev_wr),
    .event_first_o(ev_first), .event_last_o(ev_last), .active_o(active), .done_o(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Daughter readout model: one-cycle latency, word n of daughter d carries d*4096+n.
  logic mon_clr = 1'b0;
  logic pend_rd = 1'b0;
  logic [2:0] pend_addr = '0;
  int resp_idx [8];
  always @(negedge clk) begin
    pend_rd   = irs_read;
    pend_addr = irs_addr;
  end
  always @(posedge clk) begin
    #1;
    if (mon_clr) for (int d = 0; d < 8; d++) resp_idx[d] = 0;
    irs_valid = pend_rd && rst_n;
    irs_dat   = 16'($urandom);
    if (irs_valid) begin
      irs_dat = 16'(int'(pend_addr) * 4096 + resp_idx[pend_addr]);
      resp_idx[pend_addr]++;
    end
  end

  logic [15:0] g_dat [$];
  bit          g_first [$];
  bit          g_last [$];
  int          g_cyc [$];
  int          rd_cnt [8];
  int          last_rd_cyc, done_cnt, done_cyc;
  bit          done_active;
  always @(negedge clk) begin
    if (mon_clr) begin
      g_dat.delete(); g_first.delete(); g_last.delete(); g_cyc.delete();
      for (int d = 0; d < 8; d++) rd_cnt[d] = 0;
      last_rd_cyc = -1; done_cnt = 0; done_cyc = -1; done_active = 1'b0;
    end else begin
      if (ev_wr) begin
        g_dat.push_back(ev_dat); g_first.push_back(ev_first);
        g_last.push_back(ev_last); g_cyc.push_back(cyc);
      end
      if (irs_read) begin
        rd_cnt[irs_addr]++;
        last_rd_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc    = cyc;
        done_active = active;
      end
    end
  end

  logic [15:0] exp_dat [$];
  logic [3:0]  cur_mask;
  int          start_cyc;

  task automatic reg_wr(logic [3:0] a, logic [7:0] d);
    addr = a; wdat = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic rd_reg(logic [3:0] a, output logic [7:0] d);
    addr = a; #1;
    d = rdat;
  endtask

  task automatic setup(logic [3:0] m, int c0, int c1, int c2, int c3);
    int cnt [4];
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    mon_clr = 1'b1;
    @(negedge clk); @(posedge clk); #2;
    mon_clr = 1'b0;
    reg_wr(4'd8, 8'h04);
    for (int d = 0; d < 4; d++) reg_wr(4'(d), 8'(cnt[d]));
    reg_wr(4'd9, 8'(m));
    cur_mask = m;
    exp_dat.delete();
    for (int d = 0; d < 4; d++)
      if (m[d])
        for (int n = 0; n < cnt[d] * 64 + 1; n++) exp_dat.push_back(16'(d * 4096 + n));
  endtask

  task automatic start_xfer();
    addr = 4'd8; wdat = 8'h01; wr = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_done(int bound, bit bp);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      event_full = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    event_full = 1'b0;
    check_eq("done_seen", 32'(done_cnt > 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(int target, int bound);
    int n = 0;
    while (g_dat.size() < target && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("words_reached", 32'(g_dat.size() >= target), 1);
  endtask

  task automatic compare_xfer(string tag);
    int nf = 0;
    int nl = 0;
    logic [7:0] st;
    check_eq({tag, " words"}, 32'(g_dat.size()), 32'(exp_dat.size()));
    for (int i = 0; i < g_dat.size() && i < exp_dat.size(); i++)
      check_eq({tag, " data"}, 32'(g_dat[i]), 32'(exp_dat[i]));
    foreach (g_first[i]) nf += int'(g_first[i]);
    foreach (g_last[i]) nl += int'(g_last[i]);
    check_eq({tag, " first_count"}, 32'(nf), 1);
    if (g_first.size() > 0) check_eq({tag, " first_on_word0"}, 32'(g_first[0]), 1);
    check_eq({tag, " last_count"}, 32'(nl), 1);
    if (g_last.size() > 0) check_eq({tag, " last_on_final"}, 32'(g_last[g_last.size()-1]), 1);
    check_eq({tag, " done_pulses"}, 32'(done_cnt), 1);
    check_eq({tag, " active_at_done"}, 32'(done_active), 0);
    for (int d = 0; d < 4; d++)
      if (!cur_mask[d]) check_eq({tag, " disabled_reads"}, 32'(rd_cnt[d]), 0);
    rd_reg(4'd8, st);
    check_eq({tag, " status"}, 32'(st), 32'h02);
  endtask

  initial begin
    logic [7:0] r;
    int f0, n, base, abort_cyc, nl;
    rst_n = 1'b0; addr = '0; wdat = '0; wr = 1'b0; event_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst active", 32'(active), 0);
    check_eq("rst done", 32'(done), 0);
    check_eq("rst event_wr", 32'(ev_wr), 0);
    check_eq("rst read", 32'(irs_read), 0);
    check_eq("rst irs_addr", 32'(irs_addr), 0);
    rd_reg(4'd8, r); check_eq("rst csr", 32'(r), 0);
    rd_reg(4'd9, r); check_eq("rst mask", 32'(r), 32'h0F);
    rd_reg(4'd12, r); check_eq("unused addr", 32'(r), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    setup(4'hF, 1, 1, 1, 1); start_xfer(); wait_done(3000, 0); compare_xfer("all4");
    rd_reg(4'd2, r); check_eq("count readback", 32'(r), 1);
    setup(4'b0101, 2, 2, 2, 2); start_xfer(); wait_done(3000, 0); compare_xfer("mask5");
    setup(4'hF, 0, 0, 0, 0); start_xfer(); wait_done(500, 0); compare_xfer("zero_counts");
    setup(4'b1000, 0, 0, 0, 0); start_xfer(); wait_done(500, 0); compare_xfer("single_word");

    setup(4'h0, 1, 1, 1, 1); start_xfer(); wait_done(100, 0);
    check_eq("empty done_delay", 32'(done_cyc - start_cyc), 2);
    check_eq("empty writes", 32'(g_dat.size()), 0);
    check_eq("empty reads", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]), 0);
    check_eq("empty active_at_done", 32'(done_active), 0);

    // Ten-cycle FIFO backpressure burst in the middle of daughter 1.
    setup(4'hF, 1, 1, 1, 1); start_xfer(); wait_words(100, 500);
    f0 = cyc; event_full = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("bp read_low", 32'(irs_read), 0);
      @(posedge clk); #1;
    end
    event_full = 1'b0;
    wait_done(3000, 0);
    n = 0;
    foreach (g_cyc[i]) if (g_cyc[i] >= f0 + 1 && g_cyc[i] <= f0 + 11) n++;
    check_eq("bp extra_writes<=1", 32'(n <= 1), 1);
    compare_xfer("bp_burst");

    // Abort at word 30 of daughter 1.
    setup(4'hF, 1, 1, 1, 1); start_xfer(); wait_words(95, 500);
    addr = 4'd8; wdat = 8'h02; wr = 1'b1; abort_cyc = cyc;
    @(posedge clk); #1;
    wr = 1'b0;
    wait_done(50, 0);
    check_eq("abort done_pulses", 32'(done_cnt), 1);
    check_eq("abort done_timing", 32'(done_cyc - abort_cyc), 1);
    check_eq("abort active_at_done", 32'(done_active), 0);
    rd_reg(4'd8, r); check_eq("abort status", 32'(r & 8'h05), 32'h04);
    n = 0; nl = 0;
    foreach (g_cyc[i]) if (g_cyc[i] >= abort_cyc + 2) n++;
    foreach (g_last[i]) nl += int'(g_last[i]);
    check_eq("abort late_writes", 32'(n), 0);
    check_eq("abort reads_stop", 32'(last_rd_cyc < abort_cyc), 1);
    check_eq("abort no_last", 32'(nl), 0);
    check_eq("abort word_range", 32'(g_dat.size() >= 95 && g_dat.size() <= 97), 1);
    for (int i = 0; i < g_dat.size() && i < exp_dat.size(); i++)
      check_eq("abort data", 32'(g_dat[i]), 32'(exp_dat[i]));

    for (int t = 0; t < 4; t++) begin
      setup(4'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 2), $urandom_range(0, 2));
      start_xfer(); wait_done(5000, 1); compare_xfer("random");
    end

    // Asynchronous reset in the middle of a transfer, then a clean rerun.
    setup(4'hF, 1, 1, 1, 1); start_xfer(); wait_words(20, 500);
    rst_n = 1'b0; base = g_dat.size();
    #1;
    check_eq("midrst event_wr", 32'(ev_wr), 0);
    check_eq("midrst read", 32'(irs_read), 0);
    check_eq("midrst active", 32'(active), 0);
    check_eq("midrst irs_addr", 32'(irs_addr), 0);
    check_eq("midrst event_dat", 32'(ev_dat), 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst no_writes", 32'(g_dat.size()), 32'(base));
    rd_reg(4'd1, r); check_eq("midrst count_cleared", 32'(r), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    setup(4'hF, 0, 1, 0, 0); start_xfer(); wait_done(3000, 0); compare_xfer("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
